// File: rtl/fetch_load_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_load_ctrl
//
// Sequencer for a byte-addressed program memory with asynchronous
// (combinational) read. After reset it boot-loads the memory from a byte
// stream. It then fetches 32-bit big-endian instructions and presents them,
// registered, to the decode stage.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_load_valid          loader byte valid
//   i_load_byte           loader byte
//   i_load_last           final loader byte (qualified by i_load_valid)
//   o_load_ready          high while loading; a byte is accepted when
//                         i_load_valid && o_load_ready at a rising edge
//   o_mem_we/waddr/wdata  program memory byte write port (combinational)
//   o_mem_raddr           program memory read byte address
//   i_mem_rdata           word at raddr..raddr+3, big-endian
//   i_stall               decode stall: hold pc and fetch outputs
//   i_redirect            branch/jump redirect (wins over stall)
//   i_redirect_pc         redirect target byte address
//   o_instr, o_instr_pc   fetched instruction and its byte address
//   o_instr_valid         o_instr/o_instr_pc valid
//   o_load_err            sticky: the loader ran past the end of memory
//   o_state               FSM state for debug (0=LOAD, 1=RUN, 2=ERR)
//
// Handshake: the loader uses valid/ready. A byte transfers on a rising edge
// where both i_load_valid and o_load_ready are high. The loader must hold
// the byte and last flag stable until it transfers. o_load_ready does not
// depend on i_load_valid. The fetch side has no ready. i_stall is the
// back-pressure: while it is high, the presented instruction is held.
// -----------------------------------------------------------------------------
module fetch_load_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int MEM_BYTES = 32,
    parameter int RESET_PC  = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_valid,
    input  logic [7:0]        i_load_byte,
    input  logic              i_load_last,
    output logic              o_load_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_waddr,
    output logic [7:0]        o_mem_wdata,
    output logic [ADDR_W-1:0] o_mem_raddr,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_instr_pc,
    output logic              o_instr_valid,
    output logic              o_load_err,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    // MEM_BYTES is a power of two and a multiple of 4. So MEM_BYTES-4 is
    // the mask that reduces an address mod MEM_BYTES and word-aligns it
    // in one step.
    localparam logic [ADDR_W-1:0] PC_MASK    = ADDR_W'(MEM_BYTES - 4);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_BYTES - 1);
    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

    state_t              state;
    logic [ADDR_W-1:0]   load_ptr;
    logic [ADDR_W-1:0]   pc;
    logic [31:0]         instr;
    logic [ADDR_W-1:0]   instr_pc;
    logic                instr_valid;
    logic                load_err;

    logic                in_load;
    logic                in_run;

    assign in_load = (state == S_LOAD);
    assign in_run  = (state == S_RUN);

    // ------------------------------------------------------------------
    // State, pointers and registered fetch outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_LOAD;
            load_ptr    <= '0;
            pc          <= RESET_PC_A;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (i_load_valid) begin
                        load_ptr <= load_ptr + 1'b1;
                        // A last flag on the final address is a clean
                        // finish, so it is tested before the overflow case.
                        if (i_load_last) begin
                            state <= S_RUN;
                            pc    <= RESET_PC_A;
                        end else if (load_ptr == LAST_ADDR) begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (i_redirect) begin
                        // One-cycle bubble. The old instruction stays on
                        // o_instr but is marked invalid.
                        pc          <= i_redirect_pc & PC_MASK;
                        instr_valid <= 1'b0;
                    end else if (!i_stall) begin
                        instr       <= i_mem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= (pc + WORD_STEP) & PC_MASK;
                    end
                end

                S_ERR: begin
                    // Terminal until reset. Nothing is fetched.
                    instr_valid <= 1'b0;
                end

                default: begin
                    state       <= S_ERR;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory ports: only active in the state that owns them
    // ------------------------------------------------------------------
    assign o_load_ready = in_load;
    assign o_mem_we     = in_load & i_load_valid;
    assign o_mem_waddr  = in_load ? load_ptr : '0;
    assign o_mem_wdata  = in_load ? i_load_byte : 8'h00;
    assign o_mem_raddr  = in_run ? pc : '0;

    assign o_instr       = instr;
    assign o_instr_pc    = instr_pc;
    assign o_instr_valid = instr_valid;
    assign o_load_err    = load_err;
    assign o_state       = state;

endmodule

// File: tb/tb_fetch_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_load_ctrl
//
// Directed bench for fetch_load_ctrl with ADDR_W=16, MEM_BYTES=32 and
// RESET_PC=0. It includes a byte-wide program memory with combinational
// big-endian word read.
// -----------------------------------------------------------------------------
module tb_fetch_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_last;
    logic        load_ready;
    logic        mem_we;
    logic [15:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic [15:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        load_err;
    logic [1:0]  state;

    int pass_cnt;
    int check_cnt;
    int wr_count;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- program memory ----------------
    logic [7:0] mem [0:31];
    logic [4:0] ra;
    assign ra = mem_raddr[4:0];
    assign mem_rdata = {mem[ra], mem[ra + 5'd1], mem[ra + 5'd2], mem[ra + 5'd3]};

    initial wr_count = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr[4:0]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    fetch_load_ctrl #(
        .ADDR_W   (16),
        .MEM_BYTES(32),
        .RESET_PC (0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_load_valid (load_valid),
        .i_load_byte  (load_byte),
        .i_load_last  (load_last),
        .o_load_ready (load_ready),
        .o_mem_we     (mem_we),
        .o_mem_waddr  (mem_waddr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_raddr  (mem_raddr),
        .i_mem_rdata  (mem_rdata),
        .i_stall      (stall),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_instr      (instr),
        .o_instr_pc   (instr_pc),
        .o_instr_valid(instr_valid),
        .o_load_err   (load_err),
        .o_state      (state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        load_valid  = 1'b0;
        load_byte   = 8'h00;
        load_last   = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        rst_n       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        check_cnt++;
        if ({state, load_ready, load_err, mem_we, mem_raddr} !== {2'd0, 1'b1, 1'b0, 1'b0, 16'h0000})
            $display("FAIL reset_ctrl: got %h, expected %h",
                     {state, load_ready, load_err, mem_we, mem_raddr},
                     {2'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        else pass_cnt++;
        check_cnt++;
        if ({instr_valid, instr_pc, instr} !== {1'b0, 16'h0000, 32'h0})
            $display("FAIL reset_fetch: got %h, expected %h",
                     {instr_valid, instr_pc, instr}, {1'b0, 16'h0000, 32'h0});
        else pass_cnt++;
    endtask

    // 32 bytes without last: every byte written, then ERR.
    task automatic test_overflow();
        int base;
        int bad;
        base = wr_count;
        bad  = 0;
        for (int i = 0; i < 32; i++) begin
            load_valid = 1'b1;
            load_byte  = 8'(i) ^ 8'hA5;
            load_last  = 1'b0;
            #1;
            if ({mem_we, mem_waddr, mem_wdata} !== {1'b1, 16'(i), 8'(i) ^ 8'hA5}) bad++;
            tick();
        end
        check_cnt++;
        if (bad != 0) $display("FAIL ovf_write_port: got %0d bad cycles, expected 0", bad);
        else pass_cnt++;
        check_cnt++;
        if ({state, load_err, load_ready, instr_valid} !== {2'd2, 1'b1, 1'b0, 1'b0})
            $display("FAIL ovf_err_state: got %h, expected %h",
                     {state, load_err, load_ready, instr_valid}, {2'd2, 1'b1, 1'b0, 1'b0});
        else pass_cnt++;
        check_cnt++;
        if ((wr_count - base) != 32 || mem[31] !== 8'hBA)
            $display("FAIL ovf_writes: got %0d writes mem31=%h, expected 32 writes mem31=ba",
                     wr_count - base, mem[31]);
        else pass_cnt++;
        // 33rd byte and a redirect are both ignored in ERR.
        load_valid  = 1'b1;
        load_byte   = 8'h55;
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        #1;
        check_cnt++;
        if ({mem_we, mem_waddr, mem_wdata, mem_raddr} !== {1'b0, 16'h0, 8'h0, 16'h0})
            $display("FAIL err_ports: got %h, expected %h",
                     {mem_we, mem_waddr, mem_wdata, mem_raddr}, {1'b0, 16'h0, 8'h0, 16'h0});
        else pass_cnt++;
        tick();
        redirect = 1'b0;
        tick();
        load_valid = 1'b0;
        check_cnt++;
        if ({state, instr_valid, load_err} !== {2'd2, 1'b0, 1'b1} || (wr_count - base) != 32)
            $display("FAIL err_sticky: got st=%0d v=%b err=%b wr=%0d, expected st=2 v=0 err=1 wr=32",
                     state, instr_valid, load_err, wr_count - base);
        else pass_cnt++;
    endtask

    // Load 12 bytes, fetch with a 3-cycle stall at pc 8.
    task automatic test_load_and_fetch();
        logic [7:0] prog [12];
        int bad;
        int base;
        prog = '{8'h80, 8'h20, 8'h00, 8'h0A, 8'h04, 8'h40, 8'h08, 8'h00,
                 8'h0C, 8'h60, 8'h08, 8'h00};
        apply_reset();
        base = wr_count;
        bad  = 0;
        for (int i = 0; i < 12; i++) begin
            load_valid = 1'b1;
            load_byte  = prog[i];
            load_last  = (i == 11);
            #1;
            if ({load_ready, mem_we, mem_waddr, mem_wdata} !== {1'b1, 1'b1, 16'(i), prog[i]}) bad++;
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check_cnt++;
        if (bad != 0 || (wr_count - base) != 12)
            $display("FAIL load_writes: got %0d bad, %0d writes, expected 0 bad, 12 writes",
                     bad, wr_count - base);
        else pass_cnt++;
        // Edge after last byte: RUN, still no valid.
        check_cnt++;
        if ({state, load_ready, instr_valid, mem_raddr} !== {2'd1, 1'b0, 1'b0, 16'h0000})
            $display("FAIL load_to_run: got %h, expected %h",
                     {state, load_ready, instr_valid, mem_raddr}, {2'd1, 1'b0, 1'b0, 16'h0000});
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({instr_valid, instr_pc, instr, mem_raddr} !== {1'b1, 16'h0000, 32'h8020000A, 16'h0004})
            $display("FAIL fetch_pc0: got %h, expected %h",
                     {instr_valid, instr_pc, instr, mem_raddr}, {1'b1, 16'h0000, 32'h8020000A, 16'h0004});
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({instr_valid, instr_pc, instr, mem_raddr} !== {1'b1, 16'h0004, 32'h04400800, 16'h0008})
            $display("FAIL fetch_pc4: got %h, expected %h",
                     {instr_valid, instr_pc, instr, mem_raddr}, {1'b1, 16'h0004, 32'h04400800, 16'h0008});
        else pass_cnt++;
        stall = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({instr_valid, instr_pc, instr, mem_raddr} !== {1'b1, 16'h0004, 32'h04400800, 16'h0008}) bad++;
        end
        check_cnt++;
        if (bad != 0) $display("FAIL stall_hold: got %0d bad cycles, expected 0", bad);
        else pass_cnt++;
        stall = 1'b0;
        tick();
        check_cnt++;
        if ({instr_valid, instr_pc, instr, mem_raddr} !== {1'b1, 16'h0008, 32'h0C600800, 16'h000C})
            $display("FAIL fetch_pc8: got %h, expected %h",
                     {instr_valid, instr_pc, instr, mem_raddr}, {1'b1, 16'h0008, 32'h0C600800, 16'h000C});
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        // Redirect wins over stall; 0x0007 aligns to 4.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0007;
        tick();
        check_cnt++;
        if ({instr_valid, instr_pc, instr, mem_raddr} !== {1'b0, 16'h0008, 32'h0C600800, 16'h0004})
            $display("FAIL redir_bubble: got %h, expected %h",
                     {instr_valid, instr_pc, instr, mem_raddr}, {1'b0, 16'h0008, 32'h0C600800, 16'h0004});
        else pass_cnt++;
        stall    = 1'b0;
        redirect = 1'b0;
        tick();
        check_cnt++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0004, 32'h04400800})
            $display("FAIL redir_target: got %h, expected %h",
                     {instr_valid, instr_pc, instr}, {1'b1, 16'h0004, 32'h04400800});
        else pass_cnt++;
        // 0x0024 reduces mod 32 to 4.
        redirect    = 1'b1;
        redirect_pc = 16'h0024;
        tick();
        redirect = 1'b0;
        check_cnt++;
        if ({instr_valid, mem_raddr} !== {1'b0, 16'h0004})
            $display("FAIL redir_mod: got %h, expected %h", {instr_valid, mem_raddr}, {1'b0, 16'h0004});
        else pass_cnt++;
        // Stall while invalid still freezes pc.
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect = 1'b0;
        stall    = 1'b1;
        tick();
        tick();
        check_cnt++;
        if ({instr_valid, mem_raddr} !== {1'b0, 16'h0010})
            $display("FAIL stall_invalid: got %h, expected %h", {instr_valid, mem_raddr}, {1'b0, 16'h0010});
        else pass_cnt++;
        stall = 1'b0;
        tick();
        check_cnt++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0010, 32'hB5B4B7B6})
            $display("FAIL fetch_pc16: got %h, expected %h",
                     {instr_valid, instr_pc, instr}, {1'b1, 16'h0010, 32'hB5B4B7B6});
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 16'h001C;
        tick();
        redirect = 1'b0;
        tick();
        check_cnt++;
        if ({instr_valid, instr_pc, instr, mem_raddr} !== {1'b1, 16'h001C, 32'hB9B8BBBA, 16'h0000})
            $display("FAIL wrap_pc28: got %h, expected %h",
                     {instr_valid, instr_pc, instr, mem_raddr}, {1'b1, 16'h001C, 32'hB9B8BBBA, 16'h0000});
        else pass_cnt++;
        tick();
        check_cnt++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0000, 32'h8020000A})
            $display("FAIL wrap_pc0: got %h, expected %h",
                     {instr_valid, instr_pc, instr}, {1'b1, 16'h0000, 32'h8020000A});
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [7:0] prog [4];
        prog = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        #3;
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({state, load_ready, instr_valid, instr_pc, instr, mem_raddr} !==
            {2'd0, 1'b1, 1'b0, 16'h0, 32'h0, 16'h0})
            $display("FAIL async_reset: got %h, expected %h",
                     {state, load_ready, instr_valid, instr_pc, instr, mem_raddr},
                     {2'd0, 1'b1, 1'b0, 16'h0, 32'h0, 16'h0});
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        #2;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_byte  = prog[i];
            load_last  = (i == 3);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        tick();
        check_cnt++;
        if ({instr_valid, instr_pc, instr, load_err} !== {1'b1, 16'h0000, 32'hDEADBEEF, 1'b0})
            $display("FAIL reload: got %h, expected %h",
                     {instr_valid, instr_pc, instr, load_err}, {1'b1, 16'h0000, 32'hDEADBEEF, 1'b0});
        else pass_cnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        pass_cnt  = 0;
        check_cnt = 0;
        test_reset();
        test_overflow();
        test_load_and_fetch();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
